// File: rtl/mmm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mmm_pkg : shared widths, CDB payload type and EU identifiers      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package mmm_pkg;

    localparam int EU_N        = 8;
    localparam int XLEN        = 64;
    localparam int ROB_DEPTH   = 16;
    localparam int ROB_IDX_LEN = $clog2(ROB_DEPTH);
    localparam int EU_IDX_LEN  = $clog2(EU_N);

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0] rob_idx;
        logic [XLEN-1:0]        value;
        logic                   except;
    } cdb_data_t;

    typedef enum logic [EU_IDX_LEN-1:0] {
        EU_LOAD   = 3'd0,
        EU_STORE  = 3'd1,
        EU_BRANCH = 3'd2,
        EU_ALU    = 3'd3,
        EU_MULT   = 3'd4,
        EU_DIV    = 3'd5,
        EU_FPU    = 3'd6,
        EU_OPER   = 3'd7
    } eu_id_t;

    // Output-register occupancy: the only state the arbiter keeps besides the pointer.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cdb_arbiter_if : EU result ports and CDB broadcast handshake      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface cdb_arbiter_if;
    import mmm_pkg::*;

    logic      [EU_N-1:0]       eu_valid_i;
    cdb_data_t [EU_N-1:0]       eu_data_i;
    logic      [EU_N-1:0]       eu_ready_o;
    logic                       cdb_valid_o;
    cdb_data_t                  cdb_data_o;
    logic      [EU_IDX_LEN-1:0] cdb_src_o;
    logic                       cdb_ready_i;

    // slave is the arbiter's view; master is the EU/ROB side.
    modport slave (
        input  eu_valid_i, eu_data_i, cdb_ready_i,
        output eu_ready_o, cdb_valid_o, cdb_data_o, cdb_src_o
    );

    modport master (
        output eu_valid_i, eu_data_i, cdb_ready_i,
        input  eu_ready_o, cdb_valid_o, cdb_data_o, cdb_src_o
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter : N-way round-robin one-hot grant with encoded index   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_grant
);

    logic [IDX_W:0] w_k;

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        w_k       = '0;
        for (int off = 0; off < N; off++) begin
            w_k = {1'b0, ptr} + (IDX_W+1)'(off);
            if (w_k >= (IDX_W+1)'(N)) begin
                w_k = w_k - (IDX_W+1)'(N);
            end
            if (en && !any_grant && req[w_k[IDX_W-1:0]]) begin
                grant[w_k[IDX_W-1:0]] = 1'b1;
                idx                   = w_k[IDX_W-1:0];
                any_grant             = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cdb_arbiter : round-robin CDB arbiter with registered broadcast   |
// | Optional stall counter enabled by macro CDB_ARB_PERF_EN           |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module cdb_arbiter
    import mmm_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_sync_i,
    input  logic         flush_i,
    cdb_arbiter_if.slave bus
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]  perf_stall_cnt_o
`endif
);

    out_state_t            r_state;
    out_state_t            w_state_next;
    logic [EU_IDX_LEN-1:0] r_ptr;
    logic [EU_IDX_LEN-1:0] r_src;
    cdb_data_t             r_data;
    logic [EU_N-1:0]       w_grant;
    logic [EU_IDX_LEN-1:0] w_idx;
    logic                  w_load;
    logic                  w_en;
    logic                  w_any;

    assign w_load = (r_state == OUT_EMPTY) || bus.cdb_ready_i;
    assign w_en   = w_load && !flush_i && !rst_sync_i;

    rr_arbiter #(
        .N     (EU_N),
        .IDX_W (EU_IDX_LEN)
    ) u_rr (
        .req       (bus.eu_valid_i),
        .ptr       (r_ptr),
        .en        (w_en),
        .grant     (w_grant),
        .idx       (w_idx),
        .any_grant (w_any)
    );

    // Flush empties the register even under backpressure.
    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = OUT_EMPTY;
        end else if (w_load) begin
            w_state_next = w_any ? OUT_FULL : OUT_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            r_data <= '0;
            r_src  <= '0;
            r_ptr  <= '0;
        end else if (w_any) begin
            r_data <= bus.eu_data_i[w_idx];
            r_src  <= w_idx;
            r_ptr  <= (w_idx == EU_IDX_LEN'(EU_N-1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign bus.eu_ready_o  = w_grant;
    assign bus.cdb_valid_o = (r_state == OUT_FULL);
    assign bus.cdb_data_o  = r_data;
    assign bus.cdb_src_o   = r_src;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] r_stall_cnt;
    logic        w_multi;
    logic        w_stall;

    // A waiting EU loses either to backpressure or to another requester.
    assign w_multi = |(bus.eu_valid_i & (bus.eu_valid_i - 1'b1));
    assign w_stall = (|bus.eu_valid_i) &&
                     (((r_state == OUT_FULL) && !bus.cdb_ready_i) || w_multi);

    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cdb_arbiter : directed scenarios plus scoreboarded random run  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_cdb_arbiter;
    import mmm_pkg::*;

    typedef struct packed {
        cdb_data_t             d;
        logic [EU_IDX_LEN-1:0] src;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if bus ();

`ifdef CDB_ARB_PERF_EN
    logic [31:0] perf;
`endif

    cdb_arbiter dut (
        .clk_i      (clk),
        .rst_sync_i (rst),
        .flush_i    (flush),
        .bus        (bus)
`ifdef CDB_ARB_PERF_EN
        ,
        .perf_stall_cnt_o (perf)
`endif
    );

    // Reference model state, advanced once per cycle at the falling edge.
    int        m_ptr   = 0;
    bit        m_valid = 1'b0;
    sb_entry_t sb[$];
    int        g;
    logic [EU_N-1:0] exp_gnt;

    function automatic int pick(logic [EU_N-1:0] v, int p);
        for (int off = 0; off < EU_N; off++) begin
            if (v[(p + off) % EU_N]) return (p + off) % EU_N;
        end
        return -1;
    endfunction

    function automatic cdb_data_t mk(int i, int tag);
        cdb_data_t d;
        d.rob_idx = ROB_IDX_LEN'(i + tag);
        d.value   = 64'hC0DE_0000_0000_0000 | XLEN'(tag << 8) | XLEN'(i);
        d.except  = 1'(i & 1);
        return d;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            n_tests++;
            if (bus.eu_ready_o !== '0) begin
                n_fail++;
                $display("FAIL sb_reset_ready: eu_ready=%b expected 0", bus.eu_ready_o);
            end
            m_ptr   = 0;
            m_valid = 1'b0;
            sb.delete();
        end else begin
            g       = -1;
            exp_gnt = '0;
            if ((!m_valid || bus.cdb_ready_i) && !flush) g = pick(bus.eu_valid_i, m_ptr);
            if (g >= 0) exp_gnt[g] = 1'b1;
            n_tests++;
            if (bus.eu_ready_o !== exp_gnt) begin
                n_fail++;
                $display("FAIL sb_grant: eu_ready=%b expected %b", bus.eu_ready_o, exp_gnt);
            end
            n_tests++;
            if (bus.cdb_valid_o !== m_valid) begin
                n_fail++;
                $display("FAIL sb_valid: cdb_valid=%b expected %b", bus.cdb_valid_o, m_valid);
            end
            if (m_valid && sb.size() > 0) begin
                n_tests++;
                if (bus.cdb_data_o !== sb[0].d || bus.cdb_src_o !== sb[0].src) begin
                    n_fail++;
                    $display("FAIL sb_payload: data=%h src=%0d expected data=%h src=%0d",
                             bus.cdb_data_o, bus.cdb_src_o, sb[0].d, sb[0].src);
                end
            end
            if (m_valid && (flush || bus.cdb_ready_i) && sb.size() > 0) void'(sb.pop_front());
            if (flush) m_valid = 1'b0;
            else if (!m_valid || bus.cdb_ready_i) m_valid = (g >= 0);
            if (g >= 0) begin
                sb.push_back('{d: bus.eu_data_i[g], src: EU_IDX_LEN'(g)});
                m_ptr = (g + 1) % EU_N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(int tag);
        for (int k = 0; k < EU_N; k++) bus.eu_data_i[k] = mk(k, tag);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; flush = 1'b0;
        bus.eu_valid_i = '0; bus.cdb_ready_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1; flush = 1'b0;
        bus.eu_valid_i = '1; bus.cdb_ready_i = 1'b1;
        set_data(0);
        #5;
        n_tests++;
        if (bus.eu_ready_o !== '0) begin
            n_fail++;
            $display("FAIL reset_ready: eu_ready=%b expected 0", bus.eu_ready_o);
        end
        tick();
        tick();
        rst = 1'b0;
        bus.eu_valid_i = '0;
        n_tests++;
        if (bus.cdb_valid_o !== 1'b0 || bus.cdb_data_o !== '0 || bus.cdb_src_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b data=%h src=%0d expected 0/0/0",
                     bus.cdb_valid_o, bus.cdb_data_o, bus.cdb_src_o);
        end
`ifdef CDB_ARB_PERF_EN
        n_tests++;
        if (perf !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf: perf=%0d expected 0", perf);
        end
`endif
    endtask

    task automatic test_single();
        bus.eu_valid_i   = 8'b0000_1000;
        bus.eu_data_i[3] = '{rob_idx: 4'd5, value: 64'hDEAD, except: 1'b0};
        bus.cdb_ready_i  = 1'b1;
        #5;
        n_tests++;
        if (bus.eu_ready_o !== 8'b0000_1000) begin
            n_fail++;
            $display("FAIL single_grant: eu_ready=%b expected 00001000", bus.eu_ready_o);
        end
        tick();
        n_tests++;
        if (bus.cdb_valid_o !== 1'b1 || bus.cdb_data_o.rob_idx !== 4'd5 ||
            bus.cdb_data_o.value !== 64'hDEAD || bus.cdb_src_o !== EU_ALU) begin
            n_fail++;
            $display("FAIL single_bcast: valid=%b rob=%0d value=%h src=%0d expected 1/5/dead/3",
                     bus.cdb_valid_o, bus.cdb_data_o.rob_idx, bus.cdb_data_o.value, bus.cdb_src_o);
        end
        bus.eu_valid_i = '0;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        set_data(1);
        bus.eu_valid_i = '1;
        for (int i = 0; i < 9; i++) begin
            #5;
            n_tests++;
            if (bus.eu_ready_o !== (8'b1 << (i % 8))) begin
                n_fail++;
                $display("FAIL rr_grant%0d: eu_ready=%b expected %b", i, bus.eu_ready_o, 8'b1 << (i % 8));
            end
            tick();
            n_tests++;
            if (bus.cdb_valid_o !== 1'b1 || bus.cdb_src_o !== EU_IDX_LEN'(i % 8)) begin
                n_fail++;
                $display("FAIL rr_bcast%0d: valid=%b src=%0d expected 1/%0d",
                         i, bus.cdb_valid_o, bus.cdb_src_o, i % 8);
            end
        end
        bus.eu_valid_i = '0;
        tick();
    endtask

    task automatic test_wrap();
        bus.eu_valid_i = 8'h80;
        #5;
        n_tests++;
        if (bus.eu_ready_o !== 8'h80) begin
            n_fail++;
            $display("FAIL wrap_g7: eu_ready=%b expected 10000000", bus.eu_ready_o);
        end
        tick();
        bus.eu_valid_i = 8'h81;
        #5;
        n_tests++;
        if (bus.eu_ready_o !== 8'h01) begin
            n_fail++;
            $display("FAIL wrap_g0: eu_ready=%b expected 00000001", bus.eu_ready_o);
        end
        tick();
        n_tests++;
        if (bus.cdb_src_o !== EU_LOAD) begin
            n_fail++;
            $display("FAIL wrap_src0: src=%0d expected 0", bus.cdb_src_o);
        end
        #5;
        n_tests++;
        if (bus.eu_ready_o !== 8'h80) begin
            n_fail++;
            $display("FAIL wrap_g7b: eu_ready=%b expected 10000000", bus.eu_ready_o);
        end
        tick();
        bus.eu_valid_i = '0;
        tick();
    endtask

    task automatic test_backpressure();
        set_data(3);
        bus.eu_valid_i  = 8'h01;
        bus.cdb_ready_i = 1'b1;
        tick();
        bus.eu_valid_i  = 8'h06;
        bus.cdb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #5;
            n_tests++;
            if (bus.eu_ready_o !== '0) begin
                n_fail++;
                $display("FAIL bp_nogrant%0d: eu_ready=%b expected 0", i, bus.eu_ready_o);
            end
            tick();
            n_tests++;
            if (bus.cdb_valid_o !== 1'b1 || bus.cdb_data_o !== mk(0, 3) || bus.cdb_src_o !== EU_LOAD) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b data=%h src=%0d expected 1/%h/0",
                         i, bus.cdb_valid_o, bus.cdb_data_o, bus.cdb_src_o, mk(0, 3));
            end
        end
        bus.cdb_ready_i = 1'b1;
        #5;
        n_tests++;
        if (bus.eu_ready_o !== 8'h02) begin
            n_fail++;
            $display("FAIL bp_resume: eu_ready=%b expected 00000010", bus.eu_ready_o);
        end
        tick();
        n_tests++;
        if (bus.cdb_src_o !== EU_STORE || bus.cdb_data_o !== mk(1, 3)) begin
            n_fail++;
            $display("FAIL bp_after: src=%0d data=%h expected 1/%h", bus.cdb_src_o, bus.cdb_data_o, mk(1, 3));
        end
        bus.eu_valid_i = '0;
        tick();
    endtask

    task automatic test_flush();
        set_data(4);
        bus.eu_valid_i  = 8'h20;
        bus.cdb_ready_i = 1'b1;
        tick();
        bus.eu_valid_i  = 8'h44;
        bus.cdb_ready_i = 1'b0;
        flush           = 1'b1;
        #5;
        n_tests++;
        if (bus.eu_ready_o !== '0) begin
            n_fail++;
            $display("FAIL flush_nogrant: eu_ready=%b expected 0", bus.eu_ready_o);
        end
        tick();
        flush = 1'b0;
        n_tests++;
        if (bus.cdb_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: cdb_valid=%b expected 0", bus.cdb_valid_o);
        end
        bus.cdb_ready_i = 1'b1;
        #5;
        n_tests++;
        if (bus.eu_ready_o !== 8'h40) begin
            n_fail++;
            $display("FAIL flush_ptr: eu_ready=%b expected 01000000", bus.eu_ready_o);
        end
        tick();
        bus.eu_valid_i = '0;
        tick();
    endtask

`ifdef CDB_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        set_data(5);
        bus.eu_valid_i = 8'h03;
        repeat (4) tick();
        bus.eu_valid_i = '0;
        n_tests++;
        if (perf !== 32'd4) begin
            n_fail++;
            $display("FAIL perf_count: perf=%0d expected 4", perf);
        end
        tick();
        n_tests++;
        if (perf !== 32'd4) begin
            n_fail++;
            $display("FAIL perf_idle: perf=%0d expected 4", perf);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            bus.eu_valid_i  = EU_N'($urandom);
            bus.cdb_ready_i = ($urandom_range(0, 3) != 0);
            flush           = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < EU_N; k++) begin
                bus.eu_data_i[k] = '{rob_idx: ROB_IDX_LEN'($urandom),
                                     value:   {$urandom, $urandom},
                                     except:  1'($urandom)};
            end
            tick();
        end
        bus.eu_valid_i  = '0;
        bus.cdb_ready_i = 1'b1;
        flush           = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.eu_valid_i  = '0;
        bus.cdb_ready_i = 1'b1;
        bus.eu_data_i   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_flush();
`ifdef CDB_ARB_PERF_EN
        test_perf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Round-robin arbiter that shares the single Common Data Bus (CDB) among the EU_N execution-unit reservation stations (load buffer, store buffer, branch, ALU, MULT, DIV, FPU, operands-only). Each EU presents one completed result per cycle. The arbiter grants one result, registers it, and broadcasts it to the ROB and reservation stations with a valid/ready handshake. It sits between the EU result ports and the ROB write-back port.

Parameters:
- EU_N, 8, number of requesting execution units (from mmm_pkg)
- XLEN, 64, result data width (from mmm_pkg)
- ROB_DEPTH, 16, ROB entries; tag width ROB_IDX_LEN = $clog2(ROB_DEPTH)

Ports:
- clk_i  in  1  clock
- rst_sync_i  in  1  synchronous active-high reset
- flush_i  in  1  pipeline flush (mispredict/exception); drops the registered result
- eu_valid_i  in  EU_N  per-EU result valid
- eu_data_i  in  EU_N x cdb_data_t  per-EU {rob_idx, value, except}
- eu_ready_o  out  EU_N  per-EU grant; handshake completes when valid & ready
- cdb_valid_o  out  1  broadcast valid
- cdb_data_o  out  cdb_data_t  broadcast payload
- cdb_src_o  out  $clog2(EU_N)  index of the EU that produced the payload
- cdb_ready_i  in  1  ROB accepts broadcast

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset values: cdb_valid_o=0, cdb_data_o=0, cdb_src_o=0, priority pointer=0 (EU 0 highest). eu_ready_o is 0 while rst_sync_i is high.
- Output register load enable: load = !cdb_valid_o || cdb_ready_i.
- Grant (combinational):
  - When load=1 and flush_i=0, exactly one eu_ready_o bit is set: the first valid EU scanning from the pointer upward, mod EU_N.
  - Otherwise eu_ready_o = 0.
  - eu_ready_o depends on eu_valid_i; EUs must not make valid depend on ready.
- Latency: a result granted in cycle N appears on cdb_*_o in cycle N+1.
- Throughput: one result per cycle while cdb_ready_i=1.
- Register update on load:
  - cdb_valid_o = |grant; payload and src are captured from the granted EU.
  - If nothing is granted, cdb_valid_o goes to 0 and the payload holds its old value (don't care).
- Backpressure: when cdb_valid_o=1 and cdb_ready_i=0, the output holds stable, no grants are issued, and the pointer is unchanged.
- Pointer update: on a grant to EU i, pointer = (i+1) mod EU_N. No grant leaves the pointer unchanged. Wrap-around: a grant to EU EU_N-1 sets the pointer to 0.
- Flush: in the flush cycle no grant is issued, and on the next edge cdb_valid_o is cleared even if cdb_ready_i=0. The pointer is preserved.
- Reset has priority over flush.
- Starvation-free: a continuously valid EU is granted within EU_N accepted broadcasts.
- No internal FSM beyond the output-valid state, which has two states:
  - EMPTY goes to FULL on a grant.
  - FULL stays FULL on ready & grant.
  - FULL goes to EMPTY on ready & !grant, or on flush.

Optional Feature:
- Macro: CDB_ARB_PERF_EN.
- When defined: adds output port perf_stall_cnt_o (32 bits). It counts cycles with any eu_valid_i=1 but no grant, caused by backpressure or by losing arbitration with more than one requester. The counter saturates at all-ones, resets to 0, and is not affected by flush.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- mmm_pkg gains:
  - ROB_IDX_LEN = $clog2(ROB_DEPTH)
  - EU_IDX_LEN = $clog2(EU_N)
  - typedef struct packed cdb_data_t {logic [ROB_IDX_LEN-1:0] rob_idx; logic [XLEN-1:0] value; logic except;}
  - typedef enum eu_id_t naming the 8 EUs in order, with load buffer = 0.
- Sub-module rr_arbiter: parameterised N-way round-robin grant logic taking request vector, pointer and enable, and producing a one-hot grant and an encoded index. cdb_arbiter instantiates it and owns the pointer and output register.

Test Plan:
- Reset, then only EU 3 valid with rob_idx=5, value=0xDEAD, cdb_ready_i=1 -> eu_ready_o=0b00001000 in the same cycle; next cycle cdb_valid_o=1, rob_idx=5, value=0xDEAD, cdb_src_o=3.
- All 8 EUs valid continuously, ready=1, from reset -> grants in order 0,1,…,7,0; one broadcast per cycle.
- EU 7 granted, then EUs 0 and 7 valid -> EU 0 granted next (pointer wrap), then EU 7.
- cdb_ready_i=0 for 3 cycles with the output full and EUs 1 and 2 valid -> cdb_data_o stable and eu_ready_o=0 for 3 cycles; once ready=1, EU 1 is granted.
- Output full with ready=0, flush_i=1 for one cycle -> cdb_valid_o=0 next cycle, no grant during the flush cycle, pointer unchanged.
- With CDB_ARB_PERF_EN, EUs 0 and 1 valid for 4 cycles, ready=1 -> perf_stall_cnt_o=4; without the macro, the bench compiles with no perf port.
